pulse_generator: RTL and testbench

Stimulus source for the pulse-measurement path. Emits a programmed number N of single-cycle pulses, evenly distributed over each fixed measurement window of CNT_WINDOW clocks. A pulse counter using the same window length therefore reads exactly N per window. Sits between the control/UI logic (rate, start, stop) and any pulse-counting input, either on-chip loopback or a pin.

---
 rtl/pulse_generator.sv | 156 +++++++++++++++
 tb/tb_pulse_generator.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_generator.sv
// Emits N evenly spaced single-cycle pulses per CNT_WINDOW-clock window.
// Build option: PULSE_GENERATOR_ONESHOT_EN stops generation after the first window of each start.
module pulse_generator #(
    parameter logic [31:0] CNT_WINDOW = 32'd200_000_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] rate_in,
    input  logic       rate_valid_in,
    output logic       rate_ready_out,
    input  logic       start_in,
    input  logic       stop_in,
    output logic       pulse_out,
    output logic       window_out,
    output logic       busy_out,
    output logic [7:0] sent_cnt_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  act_q, act_d;
    logic [7:0]  pend_q, pend_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] tim_q, tim_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pulse_q, pulse_d;
    logic        window_q, window_d;
    logic        busy_q, busy_d;
    logic [7:0]  sent_q, sent_d;

    logic        active;
    logic        boundary;
    logic        fire;
    logic        accept;
    logic [32:0] sum_w;
    logic [31:0] acc_wrap;

    assign active   = (state_q != ST_IDLE);
    assign boundary = active && (tim_q == CNT_WINDOW - 32'd1);
    assign accept   = rate_valid_in && !pend_v_q;
    // Bresenham-style accumulator: the true sum never exceeds 2*CNT_WINDOW-1.
    assign sum_w    = {1'b0, acc_q} + {25'd0, act_q};
    assign fire     = active && (sum_w >= {1'b0, CNT_WINDOW});
    assign acc_wrap = sum_w[31:0] - CNT_WINDOW;

    always_comb begin
        state_d  = state_q;
        act_d    = act_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        acc_d    = acc_q;
        tim_d    = tim_q;
        cnt_d    = cnt_q;
        pulse_d  = 1'b0;
        window_d = 1'b0;
        sent_d   = sent_q;
        busy_d   = active;

        if (!active) begin
            acc_d = '0;
            tim_d = '0;
            cnt_d = '0;
            if (accept) begin
                act_d = rate_in;
            end
        end else begin
            acc_d    = fire ? acc_wrap : sum_w[31:0];
            pulse_d  = fire;
            window_d = boundary;
            if (boundary) begin
                tim_d  = '0;
                cnt_d  = '0;
                sent_d = cnt_q + {7'd0, fire};
            end else begin
                tim_d = tim_q + 32'd1;
                cnt_d = cnt_q + {7'd0, fire};
            end
            // A queued rate is promoted only on the boundary so each window uses one rate.
            if (boundary && pend_v_q) begin
                act_d    = pend_q;
                pend_v_d = 1'b0;
            end else if (accept) begin
                pend_d   = rate_in;
                pend_v_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_in && !stop_in) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
`ifdef PULSE_GENERATOR_ONESHOT_EN
                if (boundary) begin
                    state_d = ST_IDLE;
                end else if (stop_in) begin
                    state_d = ST_DRAIN;
                end
`else
                if (stop_in) begin
                    state_d = ST_DRAIN;
                end
`endif
            end
            ST_DRAIN: begin
                if (boundary) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            act_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            acc_q    <= '0;
            tim_q    <= '0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            window_q <= 1'b0;
            busy_q   <= 1'b0;
            sent_q   <= '0;
        end else begin
            state_q  <= state_d;
            act_q    <= act_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            acc_q    <= acc_d;
            tim_q    <= tim_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            window_q <= window_d;
            busy_q   <= busy_d;
            sent_q   <= sent_d;
        end
    end

    assign rate_ready_out = !pend_v_q;
    assign pulse_out      = pulse_q;
    assign window_out     = window_q;
    assign busy_out       = busy_q;
    assign sent_cnt_out   = sent_q;

endmodule

// File: tb/tb_pulse_generator.sv
// Bench for pulse_generator: floor-arithmetic window model checked every cycle, plus directed scenarios.
module tb_pulse_generator;

    localparam int W = 256;
`ifdef PULSE_GENERATOR_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rate = 8'd0;
    logic       rate_valid = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       ready;
    logic       pulse;
    logic       win;
    logic       busy;
    logic [7:0] sent;

    int total = 0;
    int bad = 0;
    bit model_ok = 1'b0;

    pulse_generator #(.CNT_WINDOW(32'd256)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .rate_in       (rate),
        .rate_valid_in (rate_valid),
        .rate_ready_out(ready),
        .start_in      (start),
        .stop_in       (stop),
        .pulse_out     (pulse),
        .window_out    (win),
        .busy_out      (busy),
        .sent_cnt_out  (sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Pulse count at output cycle p (1..W) of a window at rate n: step of floor(p*n/W).
    function automatic int m_fire(input int n, input int p);
        longint a;
        longint b;
        a = (longint'(p) * n) / W;
        b = (longint'(p - 1) * n) / W;
        return int'(a - b);
    endfunction

    // Reference model and per-cycle comparison.
    initial begin
        int m_pos;
        int m_act;
        int m_pend;
        bit m_pendv;
        bit m_run;
        bit m_stop;
        bit e_pulse;
        bit e_win;
        bit e_busy;
        bit e_ready;
        int e_sent;
        bit fire;
        bit bnd;
        bit acc;
        m_pos = 0; m_act = 0; m_pend = 0; m_pendv = 0; m_run = 0; m_stop = 0;
        e_pulse = 0; e_win = 0; e_busy = 0; e_ready = 1; e_sent = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_pos = 0; m_act = 0; m_pend = 0; m_pendv = 0; m_run = 0; m_stop = 0;
                e_pulse = 0; e_win = 0; e_busy = 0; e_ready = 1; e_sent = 0;
                model_ok = 1'b1;
            end else begin
                e_busy = m_run;
                fire = 0;
                bnd = 0;
                if (m_run) begin
                    fire = (m_fire(m_act, m_pos + 1) != 0);
                    bnd = (m_pos == W - 1);
                end
                e_pulse = fire;
                e_win = bnd;
                if (bnd) e_sent = m_act;
                acc = rate_valid && !m_pendv;
                if (bnd && m_pendv) begin
                    m_act = m_pend;
                    m_pendv = 0;
                end else if (acc) begin
                    if (m_run) begin
                        m_pend = rate;
                        m_pendv = 1;
                    end else begin
                        m_act = rate;
                    end
                end
                if (m_run) begin
                    m_pos = bnd ? 0 : m_pos + 1;
                    if (bnd && (m_stop || ONESHOT)) begin
                        m_run = 0;
                        m_stop = 0;
                    end else if (stop) begin
                        m_stop = 1;
                    end
                end else if (start && !stop) begin
                    m_run = 1;
                    m_pos = 0;
                    m_stop = 0;
                end
                e_ready = !m_pendv;
            end
            @(negedge clk);
            if (model_ok) begin
                check("model_pulse", pulse, e_pulse);
                check("model_window", win, e_win);
                check("model_busy", busy, e_busy);
                check("model_ready", ready, e_ready);
                check("model_sent", sent, e_sent);
            end
        end
    end

    // Leaves the bench at the negedge of run cycle 0.
    task automatic run_start(input logic [7:0] n);
        @(negedge clk);
        rate = n;
        rate_valid = 1'b1;
        @(negedge clk);
        rate_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int pq[$];
        int wq[$];
        int n2;
        int n3;
        int adj;
        bit prev;
        int wc[3];
        int first_p;
        int late_w;
        int late_p;

        check("pin_fire_4_64", m_fire(4, 64), 1);
        check("pin_fire_4_65", m_fire(4, 65), 0);
        check("pin_fire_255_1", m_fire(255, 1), 0);
        check("pin_fire_255_2", m_fire(255, 2), 1);
        check("pin_fire_8_32", m_fire(8, 32), 1);

        repeat (3) @(negedge clk);
        check("reset_pulse", pulse, 0);
        check("reset_window", win, 0);
        check("reset_busy", busy, 0);
        check("reset_ready", ready, 1);
        check("reset_sent", sent, 0);
        rst = 1'b0;

        // N=4, rate change offered at 100, stop at 300.
        run_start(8'd4);
        n2 = 0; n3 = 0; adj = 0; prev = 0;
        for (int c = 0; c <= 560; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 100) begin rate = 8'd8; rate_valid = 1'b1; end
            if (c == 101) rate_valid = 1'b0;
            if (c == 300) stop = 1'b1;
            if (c == 301) stop = 1'b0;
            if (pulse) begin
                if (c <= 256) pq.push_back(c);
                else if (c <= 512) n2++;
                else n3++;
            end
            if (c >= 1 && c <= 256 && pulse && prev) adj++;
            prev = pulse;
            if (win) wq.push_back(c);
            if (c == 101) check("n4_ready_after_offer", ready, 0);
            if (c == 255) check("n4_ready_low_to_boundary", ready, 0);
            if (c == 256) begin
                check("n4_ready_after_boundary", ready, 1);
                check("n4_sent_w1", sent, 4);
            end
            if (c == 512) check("n4_sent_w2", sent, ONESHOT ? 4 : 8);
            if (c == (ONESHOT ? 256 : 512)) check("n4_busy_last", busy, 1);
            if (c == (ONESHOT ? 257 : 513)) check("n4_busy_drop", busy, 0);
        end
        check("n4_pulse_count_w1", pq.size(), 4);
        for (int i = 0; i < 4; i++)
            check("n4_pulse_cycle", (i < pq.size()) ? pq[i] : -1, 64 * (i + 1));
        check("n4_no_adjacent", adj, 0);
        check("n8_pulse_count_w2", n2, ONESHOT ? 0 : 8);
        check("n4_after_stop_pulses", n3, 0);
        check("n4_window_count", wq.size(), ONESHOT ? 1 : 2);
        check("n4_window_first", (wq.size() > 0) ? wq[0] : -1, 256);

        // start and stop together in IDLE.
        @(negedge clk);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        repeat (10) @(negedge clk);
        check("startstop_busy", busy, 0);
        check("startstop_pulse", pulse, 0);

        // N=0 for two windows.
        run_start(8'd0);
        pq.delete();
        wq.delete();
        for (int c = 0; c <= 530; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 300) stop = 1'b1;
            if (c == 301) stop = 1'b0;
            if (pulse) pq.push_back(c);
            if (win) wq.push_back(c);
            if (c == 256) check("n0_sent", sent, 0);
        end
        check("n0_pulses", pq.size(), 0);
        check("n0_window_count", wq.size(), ONESHOT ? 1 : 2);
        check("n0_window_first", (wq.size() > 0) ? wq[0] : -1, 256);
        check("n0_window_last", (wq.size() > 0) ? wq[wq.size() - 1] : -1, ONESHOT ? 256 : 512);

        // N=255 for three windows.
        run_start(8'd255);
        wc[0] = 0; wc[1] = 0; wc[2] = 0;
        first_p = -1;
        for (int c = 0; c <= 800; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 600) stop = 1'b1;
            if (c == 601) stop = 1'b0;
            if (pulse && c >= 1 && c <= 768) begin
                wc[(c - 1) / 256]++;
                if (first_p < 0) first_p = c;
            end
            if (c == 256 || c == 512 || c == 768) check("n255_sent", sent, 255);
        end
        check("n255_first_pulse", first_p, 2);
        for (int w = 0; w < 3; w++)
            check("n255_window_count", wc[w], (ONESHOT && w > 0) ? 0 : 255);

        // Reset during RUN at cycle 130.
        run_start(8'd4);
        late_w = 0;
        late_p = 0;
        for (int c = 0; c <= 300; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 130) rst = 1'b1;
            if (c == 131) begin
                check("rst_pulse", pulse, 0);
                check("rst_window", win, 0);
                check("rst_busy", busy, 0);
                check("rst_ready", ready, 1);
                check("rst_sent", sent, 0);
                rst = 1'b0;
            end
            if (c >= 131 && win) late_w++;
            if (c >= 131 && pulse) late_p++;
        end
        check("rst_no_window_after", late_w, 0);
        check("rst_no_pulse_after", late_p, 0);

        // Randomized traffic, checked by the model process.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            case ($urandom % 4)
                0: rate = 8'd0;
                1: rate = 8'd255;
                default: rate = 8'($urandom);
            endcase
            rate_valid = ($urandom % 6 == 0);
            start = ($urandom % 90 == 0);
            stop = ($urandom % 500 == 0);
            rst = ($urandom % 2500 == 0);
        end
        @(negedge clk);
        rate_valid = 1'b0;
        start = 1'b0;
        rst = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (600) @(negedge clk);
        check("final_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
